// File: rtl/addr_mode_sequencer_if.sv
// Operand-fetch/address-generation bus between a requester and addr_mode_sequencer.
// master drives request, index and memory-read data; slave returns strobes and the effective address.
interface addr_mode_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  start;
    logic [2:0]            addr_mode;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W-1:0]     index_x;
    logic [DATA_W-1:0]     index_y;
    logic                  mem_ready;
    logic                  mem_read;
    logic                  pc_inc;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [2*DATA_W-1:0]   ea;
    logic                  ea_valid;
    logic                  page_cross;

    modport master (
        output start, addr_mode, data_in, index_x, index_y, mem_ready,
        input  mem_read, pc_inc, busy, done, err, ea, ea_valid, page_cross
    );

    modport slave (
        input  start, addr_mode, data_in, index_x, index_y, mem_ready,
        output mem_read, pc_inc, busy, done, err, ea, ea_valid, page_cross
    );
endinterface

// File: rtl/addr_mode_sequencer.sv
// Fetches operand bytes for an addressing mode and forms the effective address.
// Done 1..4 cycles after start plus one cycle per mem_ready wait; start ignored while busy.
module addr_mode_sequencer #(
    parameter int DATA_W             = 8,
    parameter int PAGE_CROSS_PENALTY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    addr_mode_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_LO = 3'd1;
    localparam logic [2:0] S_FETCH_HI = 3'd2;
    localparam logic [2:0] S_FIX_HI   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam logic [2:0] M_IMPL = 3'd0;
    localparam logic [2:0] M_IMM  = 3'd1;
    localparam logic [2:0] M_ZPG  = 3'd2;
    localparam logic [2:0] M_ZPX  = 3'd3;
    localparam logic [2:0] M_ABX  = 3'd5;
    localparam logic [2:0] M_ABY  = 3'd6;
    localparam logic [2:0] M_ILL  = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [2*DATA_W-1:0]   ea_q, ea_d;
    logic                  ea_valid_q, ea_valid_d;
    logic                  page_cross_q, page_cross_d;

    logic [DATA_W-1:0]     idx;
    logic [DATA_W:0]       sum;
    logic                  carry;
    logic [DATA_W-1:0]     hi_carry;
    logic [DATA_W-1:0]     zp_sum;
    logic [DATA_W-1:0]     hi_plus1;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        lo_d         = lo_q;
        ea_d         = ea_q;
        ea_valid_d   = ea_valid_q;
        page_cross_d = page_cross_q;

        case (mode_q)
            M_ABX:   idx = bus.index_x;
            M_ABY:   idx = bus.index_y;
            default: idx = '0;
        endcase
        sum      = {1'b0, lo_q} + {1'b0, idx};
        carry    = sum[DATA_W];
        hi_carry = bus.data_in + {{(DATA_W-1){1'b0}}, carry};
        zp_sum   = bus.data_in + bus.index_x;
        hi_plus1 = ea_q[2*DATA_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, 1'b1};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d       = bus.addr_mode;
                    ea_valid_d   = 1'b0;
                    page_cross_d = 1'b0;
                    if (bus.addr_mode == M_IMPL)     state_d = S_DONE;
                    else if (bus.addr_mode == M_ILL) state_d = S_ERR;
                    else                             state_d = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (bus.mem_ready) begin
                    lo_d = bus.data_in;
                    case (mode_q)
                        M_IMM: state_d = S_DONE;
                        M_ZPG: begin
                            ea_d       = {{DATA_W{1'b0}}, bus.data_in};
                            ea_valid_d = 1'b1;
                            state_d    = S_DONE;
                        end
                        M_ZPX: begin
                            // zero-page indexing wraps inside page zero
                            ea_d       = {{DATA_W{1'b0}}, zp_sum};
                            ea_valid_d = 1'b1;
                            state_d    = S_DONE;
                        end
                        default: state_d = S_FETCH_HI;
                    endcase
                end
            end
            S_FETCH_HI: begin
                if (bus.mem_ready) begin
                    page_cross_d = carry;
                    if (carry && (PAGE_CROSS_PENALTY != 0)) begin
                        ea_d    = {bus.data_in, sum[DATA_W-1:0]};
                        state_d = S_FIX_HI;
                    end else begin
                        ea_d       = {hi_carry, sum[DATA_W-1:0]};
                        ea_valid_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_FIX_HI: begin
                ea_d       = {hi_plus1, ea_q[DATA_W-1:0]};
                ea_valid_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                ea_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mode_q       <= M_IMPL;
            lo_q         <= '0;
            ea_q         <= '0;
            ea_valid_q   <= 1'b0;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            lo_q         <= lo_d;
            ea_q         <= ea_d;
            ea_valid_q   <= ea_valid_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mem_read   = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
    assign bus.pc_inc     = bus.mem_read && bus.mem_ready;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.ea         = ea_q;
    assign bus.ea_valid   = ea_valid_q;
    assign bus.page_cross = page_cross_q;
endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Randomized and directed check of addr_mode_sequencer against an arithmetic reference model;
// two instances (crossing penalty on and off) share the same stimulus.
module tb_addr_mode_sequencer;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    addr_mode;
    logic [DW-1:0] data_in, index_x, index_y;
    logic          mem_ready;

    always #5 clk = ~clk;

    addr_mode_sequencer_if #(.DATA_W(DW)) bus_p1 ();
    addr_mode_sequencer_if #(.DATA_W(DW)) bus_p0 ();

    assign bus_p1.start = start;     assign bus_p0.start = start;
    assign bus_p1.addr_mode = addr_mode; assign bus_p0.addr_mode = addr_mode;
    assign bus_p1.data_in = data_in; assign bus_p0.data_in = data_in;
    assign bus_p1.index_x = index_x; assign bus_p0.index_x = index_x;
    assign bus_p1.index_y = index_y; assign bus_p0.index_y = index_y;
    assign bus_p1.mem_ready = mem_ready; assign bus_p0.mem_ready = mem_ready;

    addr_mode_sequencer #(.DATA_W(DW), .PAGE_CROSS_PENALTY(1)) u_dut_p1 (
        .clk(clk), .reset(reset), .bus(bus_p1));
    addr_mode_sequencer #(.DATA_W(DW), .PAGE_CROSS_PENALTY(0)) u_dut_p0 (
        .clk(clk), .reset(reset), .bus(bus_p0));

    int total = 0;
    int bad   = 0;
    logic [15:0] m_ea;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // One operation from IDLE; called at a negedge, returns at a negedge with both DUTs idle.
    task automatic run_op(input logic [2:0] mode, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] x, input logic [7:0] y,
                          input int w0, input int w1, input bit hold);
        int exp_pcs, exp_done1, exp_done0, exp_fetch, idx, sum;
        bit legal, exp_valid, exp_pc;
        logic [15:0] exp_ea;
        int cyc, pcs, rd_cyc, done_a, done_b, err_a, err_b, k;
        int wl[2];
        logic [7:0] bytes[2];
        bit dropped;

        legal = (mode != 3'd7);
        exp_ea = m_ea; exp_valid = 0; exp_pc = 0; exp_pcs = 0;
        exp_done1 = -1; exp_done0 = -1;
        case (mode)
            3'd0: exp_done1 = 1;
            3'd1: begin exp_pcs = 1; exp_done1 = 2 + w0; end
            3'd2: begin exp_pcs = 1; exp_done1 = 2 + w0; exp_ea = 16'(lo); exp_valid = 1; end
            3'd3: begin exp_pcs = 1; exp_done1 = 2 + w0;
                        exp_ea = 16'((int'(lo) + int'(x)) % 256); exp_valid = 1; end
            3'd4, 3'd5, 3'd6: begin
                idx = (mode == 3'd5) ? int'(x) : (mode == 3'd6) ? int'(y) : 0;
                sum = int'(lo) + idx;
                exp_pc = (sum > 255);
                exp_ea = 16'((int'(hi) * 256 + sum) % 65536);
                exp_pcs = 2; exp_valid = 1;
                exp_done1 = 3 + w0 + w1 + (exp_pc ? 1 : 0);
                exp_done0 = 3 + w0 + w1;
            end
            default: ;
        endcase
        if (mode < 3'd4) exp_done0 = exp_done1;
        exp_fetch = exp_pcs + ((exp_pcs >= 1) ? w0 : 0) + ((exp_pcs >= 2) ? w1 : 0);

        wl[0] = w0; wl[1] = w1; bytes[0] = lo; bytes[1] = hi;
        start = 1'b1; addr_mode = mode; index_x = x; index_y = y;
        mem_ready = 1'b1; data_in = lo;
        cyc = 0; pcs = 0; rd_cyc = 0; done_a = -1; done_b = -1; err_a = -1; err_b = -1;
        dropped = 0;
        while (cyc < 40 && !((done_a >= 0 || err_a >= 0) && (done_b >= 0 || err_b >= 0))) begin
            @(posedge clk); @(negedge clk); cyc++;
            if (bus_p1.done && done_a < 0) done_a = cyc;
            if (bus_p0.done && done_b < 0) done_b = cyc;
            if (bus_p1.err && err_a < 0) err_a = cyc;
            if (bus_p0.err && err_b < 0) err_b = cyc;
            if (bus_p1.done || bus_p0.done || bus_p1.err || bus_p0.err) dropped = 1;
            if (hold && !dropped) begin
                start = 1'b1; addr_mode = 3'($urandom);
            end else start = 1'b0;
            if (bus_p1.mem_read) begin
                rd_cyc++;
                k = (pcs > 1) ? 1 : pcs;
                if (wl[k] > 0) begin
                    mem_ready = 1'b0; wl[k]--; data_in = 8'($urandom);
                end else begin
                    mem_ready = 1'b1; data_in = bytes[k];
                end
            end else begin
                mem_ready = 1'($urandom); data_in = 8'($urandom);
            end
            #1;
            if (bus_p1.pc_inc) pcs++;
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("done_cycle_p1", done_a, exp_done1);
        chk("done_cycle_p0", done_b, exp_done0);
        chk("err_cycle_p1", err_a, legal ? -1 : 1);
        chk("err_cycle_p0", err_b, legal ? -1 : 1);
        chk("pc_inc_count", pcs, exp_pcs);
        chk("mem_read_cycles", rd_cyc, exp_fetch);
        chk("busy_after_p1", bus_p1.busy, 0);
        chk("busy_after_p0", bus_p0.busy, 0);
        chk("done_after", bus_p1.done, 0);
        chk("ea_p1", bus_p1.ea, exp_ea);
        chk("ea_p0", bus_p0.ea, exp_ea);
        chk("ea_valid_p1", bus_p1.ea_valid, exp_valid);
        chk("ea_valid_p0", bus_p0.ea_valid, exp_valid);
        chk("page_cross_p1", bus_p1.page_cross, exp_pc);
        chk("page_cross_p0", bus_p0.page_cross, exp_pc);
        m_ea = exp_ea;
    endtask

    // Abort an ABS fetch with reset while the high byte is being fetched.
    task automatic reset_mid_op();
        bit saw_done;
        start = 1'b1; addr_mode = 3'd4; mem_ready = 1'b1; data_in = 8'h34;
        @(posedge clk); @(negedge clk);
        start = 1'b1; data_in = 8'h34;
        @(posedge clk); @(negedge clk);
        chk("mid_in_fetch_hi", bus_p1.mem_read, 1);
        reset = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1; start = 1'b0;
        chk("rst_busy", bus_p1.busy, 0);
        chk("rst_ea", bus_p1.ea, 0);
        chk("rst_ea_valid", bus_p1.ea_valid, 0);
        saw_done = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            if (bus_p1.done || bus_p0.done) saw_done = 1;
        end
        chk("rst_no_done", saw_done, 0);
        m_ea = 16'h0000;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; addr_mode = 3'd0; data_in = '0;
        index_x = '0; index_y = '0; mem_ready = 1'b0;
        m_ea = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", bus_p1.busy, 0);
        chk("rst_done0", bus_p1.done, 0);
        chk("rst_err0", bus_p1.err, 0);
        chk("rst_mem_read0", bus_p1.mem_read, 0);
        chk("rst_pc_inc0", bus_p1.pc_inc, 0);
        chk("rst_ea0", bus_p1.ea, 0);
        chk("rst_ea_valid0", bus_p1.ea_valid, 0);
        chk("rst_page_cross0", bus_p1.page_cross, 0);

        reset = 1'b1;
        run_op(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run_op(3'd3, 8'hF0, 8'h00, 8'h20, 8'h00, 0, 0, 0);
        run_op(3'd5, 8'hF0, 8'h12, 8'h20, 8'h00, 0, 0, 0);
        run_op(3'd6, 8'hFF, 8'hFF, 8'h00, 8'h01, 0, 0, 0);
        run_op(3'd4, 8'h34, 8'h12, 8'h77, 8'h88, 0, 0, 0);
        run_op(3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run_op(3'd4, 8'h34, 8'h12, 8'h00, 8'h00, 0, 2, 0);
        run_op(3'd7, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run_op(3'd2, 8'hC3, 8'h00, 8'h00, 8'h00, 1, 0, 1);
        run_op(3'd5, 8'hF0, 8'h12, 8'h20, 8'h00, 1, 1, 1);
        reset_mid_op();
        for (int n = 0; n < 300; n++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addr_mode_sequencer.md
ADDR_MODE_SEQUENCER -- requirements
Module: addr_mode_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data/index width; effective address width is 2*DATA_W.
REQ-002 SHALL have parameter PAGE_CROSS_PENALTY, default 1; 1 = extra cycle on indexed page cross, 0 = no extra cycle.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
REQ-005 start  in  1  request; accepted only in IDLE.
REQ-006 addr_mode  in  3  0 IMPL, 1 IMM, 2 ZPG, 3 ZPX, 4 ABS, 5 ABX, 6 ABY, 7 illegal.
REQ-007 data_in  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-008 index_x / index_y  in  DATA_W each  index registers, sampled in the cycle they are used.
REQ-009 mem_ready  in  1  memory handshake; 0 = wait state.
REQ-010 mem_read  out  1  operand byte fetch request at PC.
REQ-011 pc_inc  out  1  PC increment strobe, one pulse per consumed operand byte.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  one-cycle pulse on illegal mode.
REQ-015 ea  out  2*DATA_W  registered effective address.
REQ-016 ea_valid  out  1  ea meaningful (ZPG..ABY); held until next accepted start.
REQ-017 page_cross  out  1  indexed sum carried out of the low byte; held with ea.

Function
REQ-018 States SHALL be IDLE, FETCH_LO, FETCH_HI, FIX_HI, DONE, ERR.
REQ-019 IDLE + start: latch addr_mode; clear ea_valid, page_cross. IMPL -> DONE; 7 -> ERR; else -> FETCH_LO.
REQ-020 start SHALL be ignored in all non-IDLE states, including DONE and ERR.
REQ-021 FETCH_LO, FETCH_HI: mem_read=1 every cycle; state held and pc_inc=0 while mem_ready=0.
REQ-022 FETCH_LO + mem_ready: pc_inc=1; latch lo=data_in. IMM -> DONE, ea unchanged, ea_valid=0. ZPG: ea={0,lo}. ZPX: ea={0,(lo+index_x) mod 2^DATA_W}, no carry into high byte, page_cross=0. ZPG/ZPX -> DONE. ABS/ABX/ABY -> FETCH_HI.
REQ-023 FETCH_HI + mem_ready: pc_inc=1; hi=data_in; sum=lo+idx (DATA_W+1 bits), idx=0 for ABS, index_x for ABX, index_y for ABY; page_cross=sum carry.
REQ-024 No carry, or PAGE_CROSS_PENALTY=0: ea={(hi+carry) mod 2^DATA_W, sum low bits} -> DONE.
REQ-025 Carry with PAGE_CROSS_PENALTY=1: ea={hi, sum low bits} -> FIX_HI.
REQ-026 FIX_HI: exactly one cycle; ea high byte += 1 mod 2^DATA_W -> DONE.
REQ-027 The high byte SHALL wrap, so 0xFFFF+1 gives 0x0000 at DATA_W=8.
REQ-028 DONE: done=1; ea_valid=1 unless mode IMPL/IMM -> IDLE.
REQ-029 ERR: err=1, ea_valid=0 -> IDLE.
REQ-030 mem_read, pc_inc, done, err SHALL be combinational from state and mem_ready; ea, ea_valid, page_cross SHALL be registered.
REQ-031 Latency, start at cycle 0, mem_ready=1, done at cycle: IMPL 1, IMM 2, ZPG/ZPX 2, ABS 3, ABX/ABY 3, ABX/ABY with crossing and PAGE_CROSS_PENALTY=1 4; each wait cycle adds 1.
REQ-032 Total pc_inc pulses per operation: IMPL 0, IMM/ZPG/ZPX 1, ABS/ABX/ABY 2, independent of wait states.

Reset
REQ-033 reset=0 at an edge SHALL force IDLE from any state, aborting any operation without a done pulse.
REQ-034 Reset values: ea=0, ea_valid=0, page_cross=0, busy=0, done=0, err=0, mem_read=0, pc_inc=0.
REQ-035 First start SHALL be accepted on the first edge with reset=1.

Verification
REQ-036 ZPX, lo=0xF0, X=0x20 -> ea=0x0010, page_cross=0, done at cycle 2, 1 pc_inc.
REQ-037 ABX, lo=0xF0, hi=0x12, X=0x20, PAGE_CROSS_PENALTY=1 -> ea=0x1310, page_cross=1, done at cycle 4; with PAGE_CROSS_PENALTY=0 -> same ea, done at cycle 3.
REQ-038 ABY, lo=0xFF, hi=0xFF, Y=0x01 -> ea=0x0000, page_cross=1; ABS 0x34/0x12 -> ea=0x1234, page_cross=0.
REQ-039 ABS with mem_ready=0 for 2 cycles in FETCH_HI -> done at cycle 5, exactly 2 pc_inc pulses, mem_read high throughout fetch.
REQ-040 reset=0 during FETCH_HI -> next cycle IDLE, busy=0, ea=0, no done; start held high during busy -> ignored.
REQ-041 addr_mode=7 -> err pulse at cycle 1, no mem_read, busy=0 at cycle 2; IMPL -> done at cycle 1, no pc_inc.
